// File: rtl/divexec_pkg.sv
// Shared definitions for the iterative signed divide execution unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package divexec_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_TAG_W  = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BUSY = ST_BUSY,
        DONE = ST_DONE
    } state_e;

    localparam logic [31:0] DIV0_RESULT = 32'hFFFFFFFF;

endpackage

// File: rtl/divexec_div_iter_core.sv
// Unsigned restoring divider datapath: one quotient bit per step.
// Latency: W steps after load; quo_next carries the bit produced by the current step.
// Backpressure: none, sequenced entirely by the load/step controls.
module div_iter_core
    import divexec_pkg::*;
#(
    parameter int W = DEF_DATA_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quo_next
);

    logic [W-1:0] rem_q;
    logic [W-1:0] quo_q;
    logic [W-1:0] dvs_q;
    logic [W:0]   rem_sh;
    logic [W:0]   diff;
    logic         fits;
    logic [W-1:0] rem_next;

    // rem < divisor holds between steps, so rem_sh - divisor always fits W+1 signed bits
    always_comb begin
        rem_sh   = {rem_q, quo_q[W-1]};
        diff     = rem_sh - {1'b0, dvs_q};
        fits     = ~diff[W];
        rem_next = fits ? diff[W-1:0] : rem_sh[W-1:0];
        quo_next = {quo_q[W-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
        end
    end

endmodule

// File: rtl/divexec.sv
// Signed divide execution unit: accepts one divide from the issue queue and broadcasts the quotient on the CDB.
// Latency: cdb_req rises DATA_W edges after the accept edge, independent of operands.
// Backpressure: result held on the CDB until granted; a new divide is accepted only in IDLE or in the granted DONE cycle.
module divexec
    import divexec_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TAG_W  = DEF_TAG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [TAG_W-1:0]  issuediv_rdtag,
    input  logic [DATA_W-1:0] issuediv_rsdata,
    input  logic [DATA_W-1:0] issuediv_rtdata,
    input  logic              issuediv_ready,
    output logic              issuediv_done,
    output logic              cdb_req,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data,
    input  logic              cdb_grant
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             neg;
        logic             div0;
    } op_t;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    op_t               op_q;
    logic [TAG_W-1:0]  cdb_tag_q;
    logic [DATA_W-1:0] cdb_data_q;

    logic              accept;
    logic              step;
    logic              last_step;
    logic [DATA_W-1:0] rs_mag;
    logic [DATA_W-1:0] rt_mag;
    logic [DATA_W-1:0] quo_next;
    logic [DATA_W-1:0] result;

    assign rs_mag = issuediv_rsdata[DATA_W-1] ? -issuediv_rsdata : issuediv_rsdata;
    assign rt_mag = issuediv_rtdata[DATA_W-1] ? -issuediv_rtdata : issuediv_rtdata;

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        step      = 1'b0;
        last_step = 1'b0;
        case (state_q)
            IDLE: begin
                accept = issuediv_ready;
                if (accept) state_d = BUSY;
            end
            BUSY: begin
                step      = 1'b1;
                last_step = (cnt_q == CNT_W'(DATA_W - 1));
                if (last_step) state_d = DONE;
            end
            DONE: begin
                // A grant frees the unit this cycle, so a waiting divide starts without a bubble
                if (cdb_grant) begin
                    accept  = issuediv_ready;
                    state_d = issuediv_ready ? BUSY : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset) accept = 1'b0;
    end

    always_comb begin
        result = op_q.neg ? -quo_next : quo_next;
        if (op_q.div0) result = DATA_W'(DIV0_RESULT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            cdb_tag_q  <= '0;
            cdb_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q     <= '0;
                op_q.tag  <= issuediv_rdtag;
                op_q.neg  <= issuediv_rsdata[DATA_W-1] ^ issuediv_rtdata[DATA_W-1];
                op_q.div0 <= (issuediv_rtdata == '0);
            end else if (step) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (last_step) begin
                cdb_tag_q  <= op_q.tag;
                cdb_data_q <= result;
            end
        end
    end

    div_iter_core #(
        .W(DATA_W)
    ) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .step     (step),
        .dividend (rs_mag),
        .divisor  (rt_mag),
        .quo_next (quo_next)
    );

    assign issuediv_done = accept;
    assign cdb_req       = (state_q == DONE);
    assign cdb_tag       = cdb_tag_q;
    assign cdb_data      = cdb_data_q;

endmodule

// File: tb/tb_divexec.sv
// Randomized and directed self-checking bench for divexec against an arithmetic reference model.
module tb_divexec;

    logic        clk;
    logic        reset;
    logic [5:0]  issuediv_rdtag;
    logic [31:0] issuediv_rsdata;
    logic [31:0] issuediv_rtdata;
    logic        issuediv_ready;
    logic        issuediv_done;
    logic        cdb_req;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        cdb_grant;

    int checks   = 0;
    int failures = 0;

    divexec dut (
        .clk             (clk),
        .reset           (reset),
        .issuediv_rdtag  (issuediv_rdtag),
        .issuediv_rsdata (issuediv_rsdata),
        .issuediv_rtdata (issuediv_rtdata),
        .issuediv_ready  (issuediv_ready),
        .issuediv_done   (issuediv_done),
        .cdb_req         (cdb_req),
        .cdb_tag         (cdb_tag),
        .cdb_data        (cdb_data),
        .cdb_grant       (cdb_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        return sa / sb;
    endfunction

    // Waits for the result of a divide whose done was seen on the previous negedge; 33 cycles expected.
    task automatic wait_result(input logic [5:0] tag, input logic [31:0] exp);
        int lat;
        bit got;
        lat = 0;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (cdb_req) got = 1'b1;
            else if (issuediv_done) check("busy_done", issuediv_done, 1'b0);
        end
        if (!got) check("req_timeout", 32'd0, 32'd1);
        check("latency", lat, 33);
        check("cdb_tag", cdb_tag, tag);
        check("cdb_data", cdb_data, exp);
    endtask

    task automatic accept_op(input logic [5:0] tag, input logic [31:0] rs, input logic [31:0] rt);
        @(posedge clk); #1;
        issuediv_ready  = 1'b1;
        issuediv_rdtag  = tag;
        issuediv_rsdata = rs;
        issuediv_rtdata = rt;
        cdb_grant       = 1'b0;
        @(negedge clk);
        check("accept_done", issuediv_done, 1'b1);
        @(posedge clk); #1;
        issuediv_ready  = 1'($urandom_range(0, 1));
        issuediv_rdtag  = 6'($urandom);
        issuediv_rsdata = $urandom;
        issuediv_rtdata = $urandom;
    endtask

    task automatic release_cdb();
        issuediv_ready = 1'b0;
        cdb_grant      = 1'b1;
        @(posedge clk); #1;
        cdb_grant = 1'b0;
    endtask

    task automatic run_op(input logic [5:0] tag, input logic [31:0] rs, input logic [31:0] rt);
        accept_op(tag, rs, rt);
        wait_result(tag, ref_div(rs, rt));
        release_cdb();
    endtask

    localparam int NSTREAM = 8;

    initial begin
        logic [5:0]  s_tag [NSTREAM];
        logic [31:0] s_rs  [NSTREAM];
        logic [31:0] s_rt  [NSTREAM];
        logic [5:0]  tq [$];
        logic [31:0] dq [$];
        int idx, retired, age, cyc;
        bit outstanding, exp_req, exp_done;
        bit rose;

        reset = 1'b1;
        issuediv_ready  = 1'b1;
        issuediv_rdtag  = 6'h11;
        issuediv_rsdata = 32'd1;
        issuediv_rtdata = 32'd1;
        cdb_grant       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req", cdb_req, 1'b0);
        check("rst_tag", cdb_tag, 6'h0);
        check("rst_data", cdb_data, 32'h0);
        check("rst_done", issuediv_done, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        issuediv_ready = 1'b0;

        run_op(6'h2A, 32'd100, 32'd7);
        run_op(6'h01, 32'hFFFFFF9C, 32'd7);
        run_op(6'h02, 32'hFFFFFF9C, 32'hFFFFFFF9);
        run_op(6'h03, 32'h80000000, 32'hFFFFFFFF);
        run_op(6'h04, 32'd5, 32'd0);
        run_op(6'h05, 32'd6, 32'd7);

        // Grant stall with a new divide waiting
        accept_op(6'h10, 32'd1000, 32'hFFFFFFF6);
        wait_result(6'h10, 32'hFFFFFF9C);
        issuediv_ready  = 1'b1;
        issuediv_rdtag  = 6'h20;
        issuediv_rsdata = 32'd77;
        issuediv_rtdata = 32'd7;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("stall_req", cdb_req, 1'b1);
            check("stall_tag", cdb_tag, 6'h10);
            check("stall_data", cdb_data, 32'hFFFFFF9C);
            check("stall_done", issuediv_done, 1'b0);
        end
        @(posedge clk); #1;
        cdb_grant = 1'b1;
        @(negedge clk);
        check("grant_done", issuediv_done, 1'b1);
        @(posedge clk); #1;
        cdb_grant       = 1'b0;
        issuediv_ready  = 1'($urandom_range(0, 1));
        issuediv_rsdata = $urandom;
        issuediv_rtdata = $urandom;
        wait_result(6'h20, 32'd11);
        release_cdb();

        // Reset in the middle of a divide
        accept_op(6'h30, 32'd50, 32'd5);
        issuediv_ready = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        issuediv_ready = 1'b1;
        @(negedge clk);
        check("rst_mid_done", issuediv_done, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        issuediv_ready = 1'b0;
        rose = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cdb_req) rose = 1'b1;
        end
        check("rst_mid_req", rose, 1'b0);
        run_op(6'h31, 32'd9, 32'd3);

        // Back-to-back stream against a randomized grant
        for (int i = 0; i < NSTREAM; i++) begin
            s_tag[i] = 6'($urandom);
            s_rs[i]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
            s_rt[i]  = ($urandom_range(0, 4) == 0) ? 32'd0 :
                       ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 50)) - 32'd25 : $urandom;
        end
        s_rt[2] = 32'd0;
        idx = 0;
        retired = 0;
        age = 0;
        outstanding = 1'b0;
        cyc = 0;
        while (retired < NSTREAM && cyc < 3000) begin
            cyc++;
            @(posedge clk); #1;
            cdb_grant = 1'($urandom_range(0, 1));
            if (idx < NSTREAM) begin
                issuediv_ready  = 1'b1;
                issuediv_rdtag  = s_tag[idx];
                issuediv_rsdata = s_rs[idx];
                issuediv_rtdata = s_rt[idx];
            end else begin
                issuediv_ready = 1'b0;
            end
            @(negedge clk);
            if (outstanding) age++;
            exp_req  = outstanding && (age >= 33);
            exp_done = issuediv_ready && (!outstanding || (exp_req && cdb_grant));
            check("s_req", cdb_req, exp_req);
            check("s_done", issuediv_done, exp_done);
            if (exp_req && cdb_grant) begin
                if (tq.size() > 0) begin
                    check("s_tag", cdb_tag, tq.pop_front());
                    check("s_data", cdb_data, dq.pop_front());
                end
                retired++;
                outstanding = 1'b0;
            end
            if (issuediv_done && idx < NSTREAM) begin
                tq.push_back(s_tag[idx]);
                dq.push_back(ref_div(s_rs[idx], s_rt[idx]));
                outstanding = 1'b1;
                age = 0;
                idx++;
            end
        end
        check("s_retired", retired, NSTREAM);
        issuediv_ready = 1'b0;
        cdb_grant = 1'b0;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
